// File: rtl/pmp_pkg.sv
// PMP shared definitions: address-match modes, cfg byte layout, access types,
// sequential-checker states and the NAPOT mask helper.
package pmp_pkg;

  // Widest address the NAPOT helper works on; callers zero-extend and truncate.
  localparam int PMP_MAX_AW = 64;

  // Bit positions inside a pmpcfg byte {L, 2'b0, A[1:0], X, W, R}.
  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  // Address-matching mode held in cfg.A.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_addr_mode_e;

  // Access type carried by a request; the reserved code always faults.
  typedef enum logic [1:0] {
    ACC_R   = 2'd0,
    ACC_W   = 2'd1,
    ACC_X   = 2'd2,
    ACC_RSV = 2'd3
  } pmp_acc_e;

  // Sequential checker states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } pmp_seq_state_e;

  // NAPOT compare mask: clears the trailing-ones run of the encoded address
  // plus the first zero above it, leaving only the base bits set.
  function automatic logic [PMP_MAX_AW-1:0] pmp_napot_mask(
    input logic [PMP_MAX_AW-1:0] addr
  );
    return ~(addr ^ (addr + PMP_MAX_AW'(1)));
  endfunction

endpackage

// File: rtl/pmp_addr_check.sv
// Single-entry PMP address matcher. Purely combinational; the sequential
// checker time-shares one instance across all entries.
module pmp_addr_check
  import pmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  pmp_addr_mode_e        mode_i,
  input  logic [ADDR_WIDTH-1:0] pmp_addr_i,
  input  logic [ADDR_WIDTH-1:0] pmp_addr_last_i,
  input  logic [ADDR_WIDTH-1:0] napot_mask_i,
  output logic                  hit_o
);

  // Match the access address against this entry's region for its mode.
  always_comb begin
    hit_o = 1'b0;
    case (mode_i)
      TOR:     hit_o = (addr_i >= pmp_addr_last_i) && (addr_i < pmp_addr_i);
      NA4:     hit_o = (addr_i == pmp_addr_i);
      NAPOT:   hit_o = ((addr_i & napot_mask_i) == (pmp_addr_i & napot_mask_i));
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP lookup: accepts one request, walks entries 0..N-1 one per
// cycle through a shared matcher, stops at the lowest-index hit, applies the
// L/R/W/X rules and returns allow/fault on a valid/ready handshake.
module pmp_seq_checker
  import pmp_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int PMP_ENTRIES = 16,
  localparam int IDX_W       = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_vld_i,
  output logic                                   req_rdy_o,
  input  logic [ADDR_WIDTH-1:0]                  req_addr_i,
  input  logic [1:0]                             req_type_i,
  input  logic                                   req_priv_m_i,
  input  logic                                   req_kill_i,
  input  logic [PMP_ENTRIES-1:0][7:0]            pmp_cfg_i,
  input  logic [PMP_ENTRIES-1:0][ADDR_WIDTH-1:0] pmp_addr_i,
  output logic                                   resp_vld_o,
  input  logic                                   resp_rdy_i,
  output logic                                   resp_fault_o,
  output logic                                   resp_hit_o,
  output logic [IDX_W-1:0]                       resp_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PMP_ENTRIES - 1);

  pmp_seq_state_e        state_q;
  logic [IDX_W-1:0]      scanIdx_q;
  logic [ADDR_WIDTH-1:0] reqAddr_q;
  pmp_acc_e              reqType_q;
  logic                  reqPrivM_q;
  logic                  reqRdy_q;
  logic                  respVld_q;
  logic                  respFault_q;
  logic                  respHit_q;
  logic [IDX_W-1:0]      respIdx_q;

  logic [ADDR_WIDTH-1:0] curAddr;
  logic [ADDR_WIDTH-1:0] lastAddr;
  logic [ADDR_WIDTH-1:0] napotMask;
  pmp_addr_mode_e        curMode;
  logic                  entryHit;
  logic                  perm;
  logic                  hitFault_d;
  logic                  missFault_d;

  // Select the entry under scan; config is read live so late writes to
  // not-yet-scanned entries still take effect.
  always_comb begin
    curAddr   = pmp_addr_i[scanIdx_q];
    curMode   = pmp_addr_mode_e'(pmp_cfg_i[scanIdx_q][CFG_A_HI:CFG_A_LO]);
    lastAddr  = '0;
    if (scanIdx_q != '0) begin
      lastAddr = pmp_addr_i[scanIdx_q - IDX_W'(1)];
    end
    napotMask = ADDR_WIDTH'(pmp_napot_mask(PMP_MAX_AW'(curAddr)));
  end

  pmp_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_check (
    .addr_i          (reqAddr_q),
    .mode_i          (curMode),
    .pmp_addr_i      (curAddr),
    .pmp_addr_last_i (lastAddr),
    .napot_mask_i    (napotMask),
    .hit_o           (entryHit)
  );

  // Decide the fault outcome for a hit on the current entry and for a full miss.
  always_comb begin
    perm = 1'b0;
    case (reqType_q)
      ACC_R:   perm = pmp_cfg_i[scanIdx_q][CFG_R];
      ACC_W:   perm = pmp_cfg_i[scanIdx_q][CFG_W];
      ACC_X:   perm = pmp_cfg_i[scanIdx_q][CFG_X];
      default: perm = 1'b0;
    endcase
    if (!pmp_cfg_i[scanIdx_q][CFG_R] && pmp_cfg_i[scanIdx_q][CFG_W]) begin
      perm = 1'b0;
    end

    hitFault_d = ~perm;
    if (reqType_q == ACC_RSV) begin
      hitFault_d = 1'b1;
    end else if (reqPrivM_q && !pmp_cfg_i[scanIdx_q][CFG_L]) begin
      hitFault_d = 1'b0;
    end

    missFault_d = (reqType_q == ACC_RSV) || !reqPrivM_q;
  end

  // Request/scan/response FSM with all handshake and result outputs registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      scanIdx_q   <= '0;
      reqAddr_q   <= '0;
      reqType_q   <= ACC_R;
      reqPrivM_q  <= 1'b0;
      reqRdy_q    <= 1'b1;
      respVld_q   <= 1'b0;
      respFault_q <= 1'b0;
      respHit_q   <= 1'b0;
      respIdx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_vld_i && reqRdy_q && !req_kill_i) begin
            reqAddr_q  <= req_addr_i;
            reqType_q  <= pmp_acc_e'(req_type_i);
            reqPrivM_q <= req_priv_m_i;
            scanIdx_q  <= '0;
            reqRdy_q   <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (req_kill_i) begin
            respVld_q <= 1'b0;
            reqRdy_q  <= 1'b1;
            state_q   <= IDLE;
          end else if (entryHit) begin
            respVld_q   <= 1'b1;
            respHit_q   <= 1'b1;
            respIdx_q   <= scanIdx_q;
            respFault_q <= hitFault_d;
            state_q     <= RESP;
          end else if (scanIdx_q == LAST_IDX) begin
            respVld_q   <= 1'b1;
            respHit_q   <= 1'b0;
            respIdx_q   <= '0;
            respFault_q <= missFault_d;
            state_q     <= RESP;
          end else begin
            scanIdx_q <= scanIdx_q + IDX_W'(1);
          end
        end
        RESP: begin
          if (req_kill_i || resp_rdy_i) begin
            respVld_q <= 1'b0;
            reqRdy_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          respVld_q <= 1'b0;
          reqRdy_q  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign req_rdy_o    = reqRdy_q;
  assign resp_vld_o   = respVld_q;
  assign resp_fault_o = respFault_q;
  assign resp_hit_o   = respHit_q;
  assign resp_idx_o   = respIdx_q;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed testbench for pmp_seq_checker: a vector table of single-request
// scenarios followed by hand-written stall, live-config, kill and reset sequences.
module tb_pmp_seq_checker;
  import pmp_pkg::*;

  localparam int AW = 32;
  localparam int N  = 16;
  localparam int IW = 4;

  logic                  clk;
  logic                  rst;
  logic                  reqVld;
  logic                  reqRdy;
  logic [AW-1:0]         reqAddr;
  logic [1:0]            reqType;
  logic                  reqPrivM;
  logic                  reqKill;
  logic [N-1:0][7:0]     pmpCfg;
  logic [N-1:0][AW-1:0]  pmpAddr;
  logic                  respVld;
  logic                  respRdy;
  logic                  respFault;
  logic                  respHit;
  logic [IW-1:0]         respIdx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          useA;
    int            idxA;
    logic [7:0]    cfgA;
    logic [AW-1:0] addrA;
    logic          useB;
    int            idxB;
    logic [7:0]    cfgB;
    logic [AW-1:0] addrB;
    logic [AW-1:0] addr;
    logic [1:0]    acc;
    logic          privM;
    logic          expHit;
    int            expIdx;
    logic          expFault;
    int            expLat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  pmp_seq_checker #(
    .ADDR_WIDTH  (AW),
    .PMP_ENTRIES (N)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_vld_i    (reqVld),
    .req_rdy_o    (reqRdy),
    .req_addr_i   (reqAddr),
    .req_type_i   (reqType),
    .req_priv_m_i (reqPrivM),
    .req_kill_i   (reqKill),
    .pmp_cfg_i    (pmpCfg),
    .pmp_addr_i   (pmpAddr),
    .resp_vld_o   (respVld),
    .resp_rdy_i   (respRdy),
    .resp_fault_o (respFault),
    .resp_hit_o   (respHit),
    .resp_idx_o   (respIdx)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Step one clock and land just after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Turn every entry off and zero every address register.
  task automatic clearPmp();
    pmpCfg  = '0;
    pmpAddr = '0;
  endtask

  // Issue one request and count cycles from the accept edge until resp_vld.
  task automatic sendRequest(input logic [AW-1:0] addr, input logic [1:0] acc,
                             input logic privM, output int lat);
    reqAddr  = addr;
    reqType  = acc;
    reqPrivM = privM;
    reqVld   = 1'b1;
    stepCycle();
    reqVld = 1'b0;
    lat = 0;
    while (respVld !== 1'b1 && lat < 100) begin
      stepCycle();
      lat++;
    end
  endtask

  // Load a table vector's entries and run its request.
  task automatic applyStimulus(input vec_t v, output int lat);
    clearPmp();
    if (v.useA) begin
      pmpCfg[v.idxA]  = v.cfgA;
      pmpAddr[v.idxA] = v.addrA;
    end
    if (v.useB) begin
      pmpCfg[v.idxB]  = v.cfgB;
      pmpAddr[v.idxB] = v.addrB;
    end
    sendRequest(v.addr, v.acc, v.privM, lat);
  endtask

  // Complete the response handshake.
  task automatic finishResp();
    respRdy = 1'b1;
    stepCycle();
    respRdy = 1'b0;
  endtask

  // Stimulus and checking sequence.
  initial begin
    int lat;
    int seen;

    rst      = 1'b1;
    reqVld   = 1'b0;
    reqAddr  = '0;
    reqType  = 2'd0;
    reqPrivM = 1'b0;
    reqKill  = 1'b0;
    respRdy  = 1'b0;
    clearPmp();

    // cfg byte: {L,00,A,X,W,R}; A: OFF 0x00, TOR 0x08, NA4 0x10, NAPOT 0x18
    //            useA idxA cfgA   addrA     useB idxB cfgB   addrB    addr      acc   M    hit idx f    lat
    vecs[0]  = '{1'b1, 0,  8'h19, 32'h1003, 1'b0, 0, 8'h00, 32'h0,   32'h1004, 2'd0, 1'b0, 1'b1, 0,  1'b0, 1};
    vecs[1]  = '{1'b1, 0,  8'h08, 32'h0100, 1'b1, 1, 8'h11, 32'h2000, 32'h2000, 2'd0, 1'b0, 1'b1, 1,  1'b0, 2};
    vecs[2]  = '{1'b0, 0,  8'h00, 32'h0,    1'b0, 0, 8'h00, 32'h0,   32'h0040, 2'd1, 1'b1, 1'b0, 0,  1'b0, 16};
    vecs[3]  = '{1'b0, 0,  8'h00, 32'h0,    1'b0, 0, 8'h00, 32'h0,   32'h0040, 2'd1, 1'b0, 1'b0, 0,  1'b1, 16};
    vecs[4]  = '{1'b1, 3,  8'h91, 32'h0300, 1'b0, 0, 8'h00, 32'h0,   32'h0300, 2'd1, 1'b1, 1'b1, 3,  1'b1, 4};
    vecs[5]  = '{1'b1, 3,  8'h11, 32'h0300, 1'b0, 0, 8'h00, 32'h0,   32'h0300, 2'd1, 1'b1, 1'b1, 3,  1'b0, 4};
    vecs[6]  = '{1'b1, 2,  8'h1B, 32'h1003, 1'b1, 5, 8'h1C, 32'h1003, 32'h1005, 2'd2, 1'b0, 1'b1, 2,  1'b1, 3};
    vecs[7]  = '{1'b1, 0,  8'h17, 32'h0050, 1'b0, 0, 8'h00, 32'h0,   32'h0050, 2'd3, 1'b1, 1'b1, 0,  1'b1, 1};
    vecs[8]  = '{1'b1, 1,  8'h12, 32'h0060, 1'b0, 0, 8'h00, 32'h0,   32'h0060, 2'd1, 1'b0, 1'b1, 1,  1'b1, 2};
    vecs[9]  = '{1'b1, 15, 8'h11, 32'h0070, 1'b0, 0, 8'h00, 32'h0,   32'h0070, 2'd0, 1'b0, 1'b1, 15, 1'b0, 16};
    vecs[10] = '{1'b1, 4,  8'h00, 32'h0400, 1'b1, 5, 8'h0C, 32'h0500, 32'h0480, 2'd2, 1'b0, 1'b1, 5,  1'b0, 6};
    vecs[11] = '{1'b1, 4,  8'h00, 32'h0400, 1'b1, 5, 8'h0C, 32'h0500, 32'h03FF, 2'd2, 1'b0, 1'b0, 0,  1'b1, 16};
    vecs[12] = '{1'b0, 0,  8'h00, 32'h0,    1'b0, 0, 8'h00, 32'h0,   32'h0040, 2'd3, 1'b1, 1'b0, 0,  1'b1, 16};
    vecs[13] = '{1'b1, 0,  8'h14, 32'h0080, 1'b0, 0, 8'h00, 32'h0,   32'h0080, 2'd0, 1'b0, 1'b1, 0,  1'b1, 1};
    vecs[14] = '{1'b1, 6,  8'h91, 32'h0600, 1'b0, 0, 8'h00, 32'h0,   32'h0600, 2'd0, 1'b1, 1'b1, 6,  1'b0, 7};

    stepCycle();
    stepCycle();
    checkOutput("reset_req_rdy", 32'(reqRdy), 32'd1);
    checkOutput("reset_resp_vld", 32'(respVld), 32'd0);
    checkOutput("reset_resp_fault", 32'(respFault), 32'd0);
    checkOutput("reset_resp_hit", 32'(respHit), 32'd0);
    checkOutput("reset_resp_idx", 32'(respIdx), 32'd0);
    rst = 1'b0;
    stepCycle();

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d_hit", i), 32'(respHit), 32'(vecs[i].expHit));
      checkOutput($sformatf("v%0d_idx", i), 32'(respIdx), 32'(vecs[i].expIdx));
      checkOutput($sformatf("v%0d_fault", i), 32'(respFault), 32'(vecs[i].expFault));
      finishResp();
    end

    // Backpressure: response must hold steady while resp_rdy stays low.
    applyStimulus(vecs[8], lat);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall%0d_vld", c), 32'(respVld), 32'd1);
      checkOutput($sformatf("stall%0d_fault", c), 32'(respFault), 32'd1);
      checkOutput($sformatf("stall%0d_idx", c), 32'(respIdx), 32'd1);
      checkOutput($sformatf("stall%0d_req_rdy", c), 32'(reqRdy), 32'd0);
      stepCycle();
    end
    finishResp();
    checkOutput("stall_done_vld", 32'(respVld), 32'd0);
    checkOutput("stall_done_req_rdy", 32'(reqRdy), 32'd1);

    // Live config: entries 0 and 8 programmed while idx=2; only entry 8 can hit.
    clearPmp();
    reqAddr  = 32'h0900;
    reqType  = 2'd0;
    reqPrivM = 1'b0;
    reqVld   = 1'b1;
    stepCycle();
    reqVld = 1'b0;
    lat = 0;
    while (respVld !== 1'b1 && lat < 100) begin
      if (lat == 2) begin
        pmpCfg[0]  = 8'h11;
        pmpAddr[0] = 32'h0900;
        pmpCfg[8]  = 8'h11;
        pmpAddr[8] = 32'h0900;
      end
      stepCycle();
      lat++;
    end
    checkOutput("live_latency", 32'(lat), 32'd9);
    checkOutput("live_idx", 32'(respIdx), 32'd8);
    checkOutput("live_hit", 32'(respHit), 32'd1);
    checkOutput("live_fault", 32'(respFault), 32'd0);
    finishResp();

    // Kill during SCAN: back to IDLE at the next edge, no response ever.
    clearPmp();
    reqAddr  = 32'h0040;
    reqType  = 2'd1;
    reqPrivM = 1'b1;
    reqVld   = 1'b1;
    stepCycle();
    reqVld = 1'b0;
    stepCycle();
    stepCycle();
    reqKill = 1'b1;
    stepCycle();
    reqKill = 1'b0;
    checkOutput("kill_scan_req_rdy", 32'(reqRdy), 32'd1);
    checkOutput("kill_scan_vld", 32'(respVld), 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (respVld === 1'b1) seen = 1;
      stepCycle();
    end
    checkOutput("kill_scan_no_resp", 32'(seen), 32'd0);

    // Kill in IDLE blocks the accept.
    reqVld  = 1'b1;
    reqKill = 1'b1;
    stepCycle();
    reqVld  = 1'b0;
    reqKill = 1'b0;
    checkOutput("kill_idle_req_rdy", 32'(reqRdy), 32'd1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (respVld === 1'b1) seen = 1;
      stepCycle();
    end
    checkOutput("kill_idle_no_resp", 32'(seen), 32'd0);

    // Kill in RESP drops the response even without resp_rdy.
    applyStimulus(vecs[0], lat);
    checkOutput("kill_resp_pre_vld", 32'(respVld), 32'd1);
    reqKill = 1'b1;
    stepCycle();
    reqKill = 1'b0;
    checkOutput("kill_resp_vld", 32'(respVld), 32'd0);
    checkOutput("kill_resp_req_rdy", 32'(reqRdy), 32'd1);

    // Async reset mid-scan: outputs return to reset values immediately.
    applyStimulus(vecs[8], lat);
    finishResp();
    clearPmp();
    reqAddr  = 32'h0040;
    reqType  = 2'd1;
    reqPrivM = 1'b0;
    reqVld   = 1'b1;
    stepCycle();
    reqVld = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("pre_rst_req_rdy", 32'(reqRdy), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_req_rdy", 32'(reqRdy), 32'd1);
    checkOutput("rst_resp_vld", 32'(respVld), 32'd0);
    checkOutput("rst_resp_fault", 32'(respFault), 32'd0);
    checkOutput("rst_resp_hit", 32'(respHit), 32'd0);
    checkOutput("rst_resp_idx", 32'(respIdx), 32'd0);
    stepCycle();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (respVld === 1'b1) seen = 1;
      stepCycle();
    end
    checkOutput("rst_no_resp", 32'(seen), 32'd0);
    checkOutput("rst_after_req_rdy", 32'(reqRdy), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
